// File: rtl/iir_filter_gen_pkg.sv
// Package iir_pkg: default generics, width helpers and the output saturator
// shared by the IIR filter core and its sub-modules.
package iir_pkg;

  localparam int DW_DEF    = 11;
  localparam int CW_DEF    = 11;
  localparam int ORDER_DEF = 2;
  localparam int FRAC_DEF  = 10;

  // Width of the value handed to saturate(); any accumulator up to 64 bits fits.
  localparam int SAT_IN_W = 64;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Accumulator width: a full product plus guard bits for 2N+1 terms.
  function automatic int acc_width(input int dw, input int cw, input int order);
    return dw + cw + clog2(32'sd2 * order + 32'sd1);
  endfunction

  localparam int ACC_W_DEF = acc_width(DW_DEF, CW_DEF, ORDER_DEF);

  // Clamp a sign-extended accumulator value to the signed dw-bit range.
  // sat is raised whenever the value had to be clamped.
  function automatic logic signed [SAT_IN_W-1:0] saturate(
    input  logic signed [SAT_IN_W-1:0] value,
    input  int                         dw,
    output logic                       sat
  );
    logic signed [SAT_IN_W-1:0] max_v;
    logic signed [SAT_IN_W-1:0] min_v;
    max_v = (64'sd1 <<< (dw - 32'sd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 32'sd1));
    if (value > max_v) begin
      sat = 1'b1;
      return max_v;
    end else if (value < min_v) begin
      sat = 1'b1;
      return min_v;
    end else begin
      sat = 1'b0;
      return value;
    end
  endfunction

endpackage

// File: rtl/iir_filter_gen_if.sv
// Sample/coefficient bus of the IIR filter core.
//   master: drives DIN, VIN, B, A, COEF_LD; observes DOUT, VOUT, SAT
//   slave : the filter core
interface iir_filter_gen_if #(
  parameter int DW    = 11,
  parameter int CW    = 11,
  parameter int ORDER = 2
);
  logic signed [DW-1:0]           DIN;
  logic                           VIN;
  logic [(ORDER+1)*CW-1:0]        B;
  logic [ORDER*CW-1:0]            A;
  logic                           COEF_LD;
  logic signed [DW-1:0]           DOUT;
  logic                           VOUT;
  logic                           SAT;

  modport master (output DIN, VIN, B, A, COEF_LD, input  DOUT, VOUT, SAT);
  modport slave  (input  DIN, VIN, B, A, COEF_LD, output DOUT, VOUT, SAT);
endinterface

// File: rtl/iir_filter_gen_delay_line.sv
// iir_delay_line: one history line of the filter.
//   CLK, RST_n : clock, async active-low reset
//   EN         : shift D into tap 0, older taps move up
//   CLR        : synchronous clear of all taps, wins over EN
//   D          : newest value
//   TAPS       : flat taps, tap 0 (most recent) in the LSBs
module iir_delay_line #(
  parameter int W     = 11,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic             CLR,
  input  logic [W-1:0]     D,
  output logic [W*DEPTH-1:0] TAPS
);

  logic [W*DEPTH-1:0] taps_r;
  logic [W*DEPTH-1:0] shifted_s;

  // A depth-1 line has nothing older to keep, so it just takes D.
  if (DEPTH == 1) begin : g_single
    assign shifted_s = D;
  end else begin : g_multi
    assign shifted_s = {taps_r[W*(DEPTH-1)-1:0], D};
  end

  // Tap storage: clear has priority over shift.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      taps_r <= '0;
    end else if (CLR) begin
      taps_r <= '0;
    end else if (EN) begin
      taps_r <= shifted_s;
    end
  end

  assign TAPS = taps_r;

endmodule

// File: rtl/iir_filter_gen.sv
// iir_filter_gen: parametrised direct-form-I IIR filter with run-time
// coefficient load, output saturation and VIN-gated state advance.
//   CLK, RST_n : clock, async active-low reset
//   bus (slave): DIN/VIN sample in, B/A coefficients with COEF_LD,
//                DOUT/VOUT/SAT result two edges after VIN
module iir_filter_gen
  import iir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int ORDER = ORDER_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic            CLK,
  input  logic            RST_n,
  iir_filter_gen_if.slave bus
);

  localparam int PW    = DW + CW;
  localparam int ACC_W = acc_width(DW, CW, ORDER);

  logic signed [CW-1:0]       b_sh_r [0:ORDER];
  logic signed [CW-1:0]       a_sh_r [1:ORDER];
  logic signed [DW-1:0]       x_reg_r;
  logic                       v_reg_r;
  logic signed [DW-1:0]       dout_r;
  logic                       vout_r;
  logic                       sat_r;

  logic [ORDER*DW-1:0]        x_taps_s;
  logic [ORDER*DW-1:0]        y_taps_s;
  logic signed [DW-1:0]       xv_s [0:ORDER];
  logic signed [DW-1:0]       yv_s [1:ORDER];
  logic signed [PW-1:0]       prod_s;
  logic signed [ACC_W-1:0]    acc_s;
  logic signed [ACC_W-1:0]    shifted_s;
  logic signed [SAT_IN_W-1:0] sat_out_s;
  logic                       sat_s;
  logic signed [DW-1:0]       y_sat_s;

  // Shadow coefficients: only COEF_LD lets the live B/A bus in.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k <= ORDER; k++) b_sh_r[k] <= '0;
      for (int k = 1; k <= ORDER; k++) a_sh_r[k] <= '0;
    end else if (bus.COEF_LD) begin
      for (int k = 0; k <= ORDER; k++) b_sh_r[k] <= bus.B[k*CW +: CW];
      for (int k = 1; k <= ORDER; k++) a_sh_r[k] <= bus.A[(k-1)*CW +: CW];
    end
  end

  // Input stage: capture the sample and mark it in flight.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      x_reg_r <= '0;
      v_reg_r <= 1'b0;
    end else begin
      if (bus.VIN) begin
        x_reg_r <= bus.DIN;
      end
      v_reg_r <= bus.VIN;
    end
  end

  // Histories advance only when a result is emitted; COEF_LD clears them.
  iir_delay_line #(.W(DW), .DEPTH(ORDER)) u_x_line (
    .CLK  (CLK),
    .RST_n(RST_n),
    .EN   (v_reg_r),
    .CLR  (bus.COEF_LD),
    .D    (x_reg_r),
    .TAPS (x_taps_s)
  );

  iir_delay_line #(.W(DW), .DEPTH(ORDER)) u_y_line (
    .CLK  (CLK),
    .RST_n(RST_n),
    .EN   (v_reg_r),
    .CLR  (bus.COEF_LD),
    .D    (y_sat_s),
    .TAPS (y_taps_s)
  );

  // Single-cycle MAC, arithmetic shift (floor) and clamp.
  always_comb begin
    xv_s[0] = x_reg_r;
    for (int k = 1; k <= ORDER; k++) begin
      xv_s[k] = x_taps_s[(k-1)*DW +: DW];
      yv_s[k] = y_taps_s[(k-1)*DW +: DW];
    end
    prod_s = '0;
    acc_s  = '0;
    for (int k = 0; k <= ORDER; k++) begin
      prod_s = PW'(xv_s[k]) * PW'(b_sh_r[k]);
      acc_s  = acc_s + ACC_W'(prod_s);
    end
    for (int k = 1; k <= ORDER; k++) begin
      prod_s = PW'(yv_s[k]) * PW'(a_sh_r[k]);
      acc_s  = acc_s - ACC_W'(prod_s);
    end
    shifted_s = acc_s >>> FRAC;
    sat_out_s = saturate(SAT_IN_W'(shifted_s), DW, sat_s);
    y_sat_s   = DW'(sat_out_s);
  end

  // Output stage: DOUT/SAT hold between results, VOUT is a one-cycle pulse.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dout_r <= '0;
      sat_r  <= 1'b0;
      vout_r <= 1'b0;
    end else begin
      if (v_reg_r) begin
        dout_r <= y_sat_s;
        sat_r  <= sat_s;
      end
      vout_r <= v_reg_r;
    end
  end

  assign bus.DOUT = dout_r;
  assign bus.VOUT = vout_r;
  assign bus.SAT  = sat_r;

endmodule

// File: tb/tb_iir_filter_gen.sv
// Directed bench for iir_filter_gen (DW=CW=11, FRAC=10, ORDER=2).
module tb_iir_filter_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   decay_exp [10] = '{200, 100, 50, 25, 12, 6, 3, 1, 0, 0};

  iir_filter_gen_if #(.DW(11), .CW(11), .ORDER(2)) bus ();

  iir_filter_gen #(.DW(11), .CW(11), .ORDER(2), .FRAC(10)) dut (
    .CLK  (clk),
    .RST_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input int vout, input int dout, input int sat);
    check_val({tag, " vout"}, int'(bus.VOUT), vout);
    check_val({tag, " dout"}, int'($signed(bus.DOUT)), dout);
    check_val({tag, " sat"},  int'(bus.SAT), sat);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic signed [10:0] b0, input logic signed [10:0] b1,
                      input logic signed [10:0] b2, input logic signed [10:0] a1,
                      input logic signed [10:0] a2);
    bus.B       = {b2, b1, b0};
    bus.A       = {a2, a1};
    bus.COEF_LD = 1'b1;
    bus.VIN     = 1'b0;
    step();
    bus.COEF_LD = 1'b0;
  endtask

  // Impulse 400 then zeros; gap > 0 inserts gap idle cycles after each sample.
  task automatic run_decay(input int gap, input string tag);
    for (int i = 0; i < 10; i++) begin
      bus.DIN = (i == 0) ? 11'sd400 : 11'sd0;
      bus.VIN = 1'b1;
      step();
      if (gap > 0) begin
        bus.VIN = 1'b0;
        check_val($sformatf("%s s%0d stage1 vout", tag, i), int'(bus.VOUT), 0);
        step();
        check_out($sformatf("%s s%0d", tag, i), 1, decay_exp[i], 0);
        for (int g = 1; g < gap; g++) begin
          step();
          check_val($sformatf("%s s%0d gap%0d vout", tag, i, g), int'(bus.VOUT), 0);
        end
      end else if (i == 0) begin
        check_val({tag, " first vout"}, int'(bus.VOUT), 0);
      end else begin
        check_out($sformatf("%s s%0d", tag, i - 1), 1, decay_exp[i-1], 0);
      end
    end
    bus.VIN = 1'b0;
    if (gap == 0) begin
      step();
      check_out({tag, " s9"}, 1, decay_exp[9], 0);
    end
    step();
    check_val({tag, " drained vout"}, int'(bus.VOUT), 0);
  endtask

  initial begin
    bus.DIN     = '0;
    bus.VIN     = 1'b0;
    bus.B       = '0;
    bus.A       = '0;
    bus.COEF_LD = 1'b0;
    step();
    step();
    check_out("reset", 0, 0, 0);
    rst_n = 1'b1;
    step();

    // Zero shadows before any load: a sample still comes out, as 0.
    bus.DIN = 11'sd400; bus.VIN = 1'b1; step();
    bus.VIN = 1'b0; step();
    check_out("no coef", 1, 0, 0);

    // Pure gain and latency.
    load(11'sd512, 11'sd0, 11'sd0, 11'sd0, 11'sd0);
    bus.DIN = 11'sd400; bus.VIN = 1'b1; step();
    bus.VIN = 1'b0;
    check_val("gain lat1 vout", int'(bus.VOUT), 0);
    step();
    check_out("gain +400", 1, 200, 0);
    step();
    check_val("gain pulse end", int'(bus.VOUT), 0);
    bus.DIN = -11'sd400; bus.VIN = 1'b1; step();
    bus.VIN = 1'b0; step();
    check_out("gain -400", 1, -200, 0);

    // Feedback decay, back to back and with VIN gaps.
    load(11'sd512, 11'sd0, 11'sd0, -11'sd512, 11'sd0);
    run_decay(0, "decay");
    load(11'sd512, 11'sd0, 11'sd0, -11'sd512, 11'sd0);
    run_decay(5, "gaps");

    // Saturation at both rails.
    load(11'sd1023, 11'sd1023, 11'sd0, 11'sd0, 11'sd0);
    bus.VIN = 1'b1;
    bus.DIN = 11'sd1023;  step();
    bus.DIN = 11'sd1023;  step(); check_out("sat p1", 1, 1022, 0);
    bus.DIN = -11'sd1024; step(); check_out("sat p2", 1, 1023, 1);
    bus.DIN = -11'sd1024; step(); check_out("sat n1", 1, -1, 0);
    bus.VIN = 1'b0;       step(); check_out("sat n2", 1, -1024, 1);

    // COEF_LD with a sample in flight and a new sample on the same edge.
    load(11'sd512, 11'sd0, 11'sd0, -11'sd512, 11'sd0);
    bus.VIN = 1'b1;
    bus.DIN = 11'sd400; step();
    bus.DIN = 11'sd0;   step(); check_out("mid y0", 1, 200, 0);
    bus.DIN = 11'sd0;   step(); check_out("mid y1", 1, 100, 0);
    bus.DIN = 11'sd400;
    bus.B = {11'sd0, 11'sd0, 11'sd512};
    bus.A = {11'sd0, 11'sd0};
    bus.COEF_LD = 1'b1; step(); check_out("mid inflight", 1, 50, 0);
    bus.COEF_LD = 1'b0;
    bus.DIN = 11'sd0;   step(); check_out("mid new", 1, 200, 0);
    bus.VIN = 1'b0;     step(); check_out("mid nohist", 1, 0, 0);

    // Async reset between VIN and VOUT.
    load(11'sd512, 11'sd0, 11'sd0, -11'sd512, 11'sd0);
    bus.VIN = 1'b1;
    bus.DIN = 11'sd400; step();
    bus.DIN = 11'sd400; step(); check_out("rst pre", 1, 200, 0);
    bus.VIN = 1'b0;
    rst_n = 1'b0;
    #1;
    check_out("rst async", 0, 0, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("rst after%0d vout", i), int'(bus.VOUT), 0);
    end
    load(11'sd512, 11'sd0, 11'sd0, -11'sd512, 11'sd0);
    run_decay(0, "post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
